// File: rtl/dmem_result_dumper.sv
// Reads a window of data-BRAM words after a start request and streams each word
// LSB byte first over an 8N1 UART transmitter so a host can capture the results.
module dmem_result_dumper #(
  parameter int ADDR_WIDTH   = 10,
  parameter int START_ADDR   = 0,
  parameter int NUM_WORDS    = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  output logic                  o_mem_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [31:0]           i_mem_rd_data,
  output logic                  o_uart_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int WCNT_W = ADDR_WIDTH + 1;
  localparam logic [BAUD_W-1:0]     BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [WCNT_W-1:0]     WORD_TOTAL = WCNT_W'(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(START_ADDR);

  typedef enum logic [3:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    LOAD,
    TX_START,
    TX_DATA,
    TX_STOP,
    NEXT,
    FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [1:0]            byte_q, byte_d;
  logic [WCNT_W-1:0]     word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  mem_en_q, mem_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  baud_end;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    word_d   = word_q;
    addr_d   = addr_q;
    shift_d  = shift_q;
    baud_end = (baud_q == BAUD_LAST);

    case (state_q)
      IDLE, FINISH: begin
        if (i_start) begin
          state_d = RD_REQ;
          word_d  = '0;
          addr_d  = ADDR_FIRST;
        end
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: begin
        // BRAM data is valid only during this cycle, so the snapshot is taken
        // on the edge that enters LOAD.
        shift_d = i_mem_rd_data;
        state_d = LOAD;
      end
      LOAD: begin
        byte_d  = 2'd0;
        bit_d   = 3'd0;
        baud_d  = '0;
        state_d = TX_START;
      end
      TX_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = TX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            shift_d = {8'h00, shift_q[31:8]};
            state_d = TX_START;
          end else begin
            state_d = NEXT;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      NEXT: begin
        word_d = word_q + WCNT_W'(1);
        addr_d = addr_q + 1'b1;
        if (word_d == WORD_TOTAL) begin
          state_d = FINISH;
        end else begin
          state_d = RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so the serial line is glitch-free.
    mem_en_d = (state_d == RD_REQ);
    busy_d   = !((state_d == IDLE) || (state_d == FINISH));
    done_d   = (state_d == FINISH);
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[bit_d];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      byte_q   <= 2'd0;
      word_q   <= '0;
      addr_q   <= ADDR_FIRST;
      shift_q  <= 32'd0;
      tx_q     <= 1'b1;
      mem_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      word_q   <= word_d;
      addr_q   <= addr_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      mem_en_q <= mem_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_mem_en   = mem_en_q;
  assign o_mem_addr = addr_q;
  assign o_uart_tx  = tx_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_dmem_result_dumper.sv
// Scoreboard bench: three dumper configurations, a BRAM model per instance and a
// UART frame monitor per instance that pops expected bytes as frames arrive.
module tb_dmem_result_dumper;

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         gap;
  } byte_exp_t;

  typedef struct {
    int         inst;
    logic [9:0] addr;
  } addr_exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start [3];
  logic        en_w [3];
  logic [9:0]  addr_w [3];
  logic [31:0] rd_w [3];
  logic        tx_w [3];
  logic        busy_w [3];
  logic        done_w [3];
  logic [9:0]  addr_a, addr_c;
  logic [3:0]  addr_b;
  logic [31:0] mem [3][16];
  logic        en_d1 [3];

  byte_exp_t byte_q [$];
  addr_exp_t addr_q [$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign addr_w[0] = addr_a;
  assign addr_w[1] = {6'd0, addr_b};
  assign addr_w[2] = addr_c;

  dmem_result_dumper #(.ADDR_WIDTH(10), .START_ADDR(0), .NUM_WORDS(2), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .i_start(start[0]), .o_mem_en(en_w[0]), .o_mem_addr(addr_a),
    .i_mem_rd_data(rd_w[0]), .o_uart_tx(tx_w[0]), .o_busy(busy_w[0]), .o_done(done_w[0]));

  dmem_result_dumper #(.ADDR_WIDTH(4), .START_ADDR(15), .NUM_WORDS(3), .CLKS_PER_BIT(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .i_start(start[1]), .o_mem_en(en_w[1]), .o_mem_addr(addr_b),
    .i_mem_rd_data(rd_w[1]), .o_uart_tx(tx_w[1]), .o_busy(busy_w[1]), .o_done(done_w[1]));

  dmem_result_dumper #(.ADDR_WIDTH(10), .START_ADDR(0), .NUM_WORDS(1), .CLKS_PER_BIT(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .i_start(start[2]), .o_mem_en(en_w[2]), .o_mem_addr(addr_c),
    .i_mem_rd_data(rd_w[2]), .o_uart_tx(tx_w[2]), .o_busy(busy_w[2]), .o_done(done_w[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL %s: got %h expected nothing (cycle %0d)", name, act, cyc);
  endtask

  // BRAM model: registered read, data held valid for exactly one cycle, then scrambled.
  initial begin
    addr_exp_t ae;
    for (int i = 0; i < 3; i++) begin
      en_d1[i] = 1'b0;
      rd_w[i]  = 32'd0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        en_d1[i] <= en_w[i];
        if (en_w[i]) begin
          rd_w[i] <= mem[i][addr_w[i][3:0]];
          chk("mem_en_single_cycle", 32'(en_d1[i]), 32'd0);
          if (addr_q.size() == 0) begin
            fail_now("rd_addr_unexpected", 32'(addr_w[i]));
          end else begin
            ae = addr_q.pop_front();
            chk("rd_addr_inst", 32'(i), 32'(ae.inst));
            chk("rd_addr", 32'(addr_w[i]), 32'(ae.addr));
          end
        end else if (en_d1[i]) begin
          rd_w[i] <= ~rd_w[i];
        end
      end
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_mon
    localparam int C = (gi == 2) ? 2 : 4;
    initial begin
      logic      prev;
      logic      aborted;
      logic [9:0] frame;
      int        t0;
      int        last_start;
      byte_exp_t e;
      prev       = 1'b1;
      last_start = 0;
      forever begin
        @(negedge clk);
        if (reset_n === 1'b1 && prev === 1'b1 && tx_w[gi] === 1'b0) begin
          t0      = cyc;
          aborted = 1'b0;
          frame   = '0;
          for (int k = 0; k < 10 * C; k++) begin
            if (k > 0) @(negedge clk);
            if (reset_n !== 1'b1) aborted = 1'b1;
            if ((k % C) == (C / 2)) frame[k / C] = tx_w[gi];
          end
          if (!aborted) begin
            if (byte_q.size() == 0) begin
              fail_now("byte_unexpected", 32'(frame));
            end else begin
              e = byte_q.pop_front();
              chk("byte_inst", 32'(gi), 32'(e.inst));
              chk("byte_data", 32'(frame[8:1]), 32'(e.data));
              chk("frame_start_stop", 32'({frame[9], frame[0]}), 32'd2);
              if (e.gap != 0) chk("byte_spacing", 32'(t0 - last_start), 32'(e.gap));
            end
          end
          last_start = t0;
        end
        prev = tx_w[gi];
      end
    end
  end

  task automatic push_word(input int inst, input logic [9:0] a, input logic [31:0] d,
                           input int g0, input int c);
    addr_exp_t ae;
    byte_exp_t be;
    ae.inst = inst;
    ae.addr = a;
    addr_q.push_back(ae);
    for (int b = 0; b < 4; b++) begin
      be.inst = inst;
      be.data = d[8*b +: 8];
      be.gap  = (b == 0) ? g0 : 10 * c;
      byte_q.push_back(be);
    end
  endtask

  // Leaves the bench at the negedge of the first cycle after the accept edge.
  task automatic pulse_start(input int i, output int acc);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(input int i, input int bound);
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (done_w[i]) break;
    end
    chk("run_completes", 32'(done_w[i]), 32'd1);
    chk("busy_after_run", 32'(busy_w[i]), 32'd0);
  endtask

  initial begin
    int         acc;
    logic       idle_ok;
    logic [9:0] seq;
    addr_exp_t  ae;
    byte_exp_t  be;

    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 16; j++) mem[i][j] = 32'h0;
    mem[0][0]  = 32'h44332211;
    mem[0][1]  = 32'hDEADBEEF;
    mem[1][15] = 32'h0A0B0C0D;
    mem[1][0]  = 32'h12345678;
    mem[1][1]  = 32'h80FF017F;
    mem[2][0]  = 32'h000000A5;

    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx_w[0]), 32'd1);
    chk("reset_mem_en", 32'(en_w[0]), 32'd0);
    chk("reset_busy", 32'(busy_w[0]), 32'd0);
    chk("reset_done", 32'(done_w[0]), 32'd0);
    chk("reset_addr_a", 32'(addr_a), 32'd0);
    chk("reset_addr_b", 32'(addr_b), 32'd15);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic dump with two ignored start pulses during the run.
    push_word(0, 10'd0, 32'h44332211, 0, 4);
    push_word(0, 10'd1, 32'hDEADBEEF, 44, 4);
    chk("busy_before_start", 32'(busy_w[0]), 32'd0);
    pulse_start(0, acc);
    chk("busy_after_accept", 32'(busy_w[0]), 32'd1);
    for (int n = 1; n <= 340; n++) begin
      @(negedge clk);
      start[0] = (n == 49 || n == 199) ? 1'b1 : 1'b0;
      if (n == 2) chk("tx_idle_before_start_bit", 32'(tx_w[0]), 32'd1);
      if (n == 3) chk("tx_start_bit_latency", 32'(tx_w[0]), 32'd0);
      if (n == 327) chk("done_not_early", 32'(done_w[0]), 32'd0);
      if (n == 328) begin
        chk("done_at_328", 32'(done_w[0]), 32'd1);
        chk("busy_low_at_328", 32'(busy_w[0]), 32'd0);
      end
    end
    start[0] = 1'b0;
    chk("done_held", 32'(done_w[0]), 32'd1);

    // Restart from FINISH: second full dump.
    push_word(0, 10'd0, 32'h44332211, 0, 4);
    push_word(0, 10'd1, 32'hDEADBEEF, 44, 4);
    pulse_start(0, acc);
    chk("restart_done_drops", 32'(done_w[0]), 32'd0);
    chk("restart_busy_rises", 32'(busy_w[0]), 32'd1);
    wait_done(0, 400);

    // Reset during bit 2 of byte 2 (0x33, bit 2 = 0).
    ae.inst = 0;
    ae.addr = 10'd0;
    addr_q.push_back(ae);
    be.inst = 0; be.data = 8'h11; be.gap = 0;
    byte_q.push_back(be);
    be.data = 8'h22; be.gap = 40;
    byte_q.push_back(be);
    pulse_start(0, acc);
    for (int n = 1; n <= 96; n++) @(negedge clk);
    chk("tx_low_before_reset", 32'(tx_w[0]), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("midreset_tx", 32'(tx_w[0]), 32'd1);
    chk("midreset_busy", 32'(busy_w[0]), 32'd0);
    chk("midreset_done", 32'(done_w[0]), 32'd0);
    chk("midreset_mem_en", 32'(en_w[0]), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle_ok = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || en_w[0] !== 1'b0) idle_ok = 1'b0;
    end
    chk("idle_after_reset", 32'(idle_ok), 32'd1);

    // Address wrap: 15, 0, 1.
    push_word(1, 10'd15, 32'h0A0B0C0D, 0, 4);
    push_word(1, 10'd0, 32'h12345678, 44, 4);
    push_word(1, 10'd1, 32'h80FF017F, 44, 4);
    pulse_start(1, acc);
    wait_done(1, 3 * 164 + 20);

    // Exact bit timing at two clocks per bit.
    push_word(2, 10'd0, 32'h000000A5, 0, 2);
    seq = 10'b1101001010;
    pulse_start(2, acc);
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      if (n >= 3) chk("bit_timing", 32'(tx_w[2]), 32'(seq[(n - 3) / 2]));
    end
    wait_done(2, 100);

    repeat (10) @(negedge clk);
    chk("byte_queue_drained", 32'(byte_q.size()), 32'd0);
    chk("addr_queue_drained", 32'(addr_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
